cache_flush_engine: RTL and testbench
=====================================

# cache_flush_engine

Walks all 8 sets of a cache's metadata and data arrays and writes every valid, dirty line back to physical memory, then clears its dirty bit. It optionally also clears the valid bit. It sits beside the cache control FSM. While `busy` is high, it owns the read index and the dirty/valid write ports of the arrays through an external mux. It drives the same burst-line physical-memory write interface the cache uses for evictions.

## Interface
- `S_OFFSET`, 5, line offset bits (32-byte line)
- `S_TAG`, 24, tag width (32 − 3 index − S_OFFSET)
- `S_LINE`, 256, line width in bits
- `INVALIDATE`, 0, if 1, also clear the valid bit of every valid line visited

- `clk` in 1: the only clock
- `rst` in 1: synchronous, active-high reset
- `flush_req` in 1: start request, sampled only in IDLE
- `busy` out 1: engine owns the array ports; also the external mux select
- `flush_done` out 1: one-cycle completion pulse
- `arr_rindex` out 3: read index to the tag/valid/dirty/data arrays
- `valid_in` in 1, `dirty_in` in 1, `tag_in` in S_TAG, `line_in` in S_LINE: combinational array outputs at `arr_rindex`
- `dirty_load` out 1, `valid_load` out 1: array write enables
- `arr_windex` out 3: array write index
- `arr_datain` out 1: constant 0
- `pmem_address` out 32, `pmem_wdata` out S_LINE, `pmem_write` out 1, `pmem_resp` in 1: memory write handshake

## Operation
- States: IDLE, CHECK, WRITE, CLEAR, DONE. A 3-bit `idx` register tracks the current set.
- IDLE: `busy`=0, `idx`=0. If `flush_req`=1, go to CHECK.
- CHECK: `arr_rindex`=`idx`.
  - If `valid_in & dirty_in`: latch `tag_in`→`tag_q` and `line_in`→`line_q`, then go to WRITE.
  - Else if `INVALIDATE & valid_in`: go to CLEAR.
  - Else if `idx`==7: go to DONE.
  - Else: `idx`++ and stay in CHECK.
- WRITE: `pmem_write`=1, `pmem_address`={`tag_q`, `idx`, S_OFFSET'b0}, `pmem_wdata`=`line_q`. Address and data come from registers and stay stable until `pmem_resp`. On `pmem_resp`=1, go to CLEAR.
- CLEAR:
  - `arr_windex`=`idx`, `dirty_load`=1, `valid_load`=`INVALIDATE`.
  - Writing a clean line's dirty bit to 0 is permitted and harmless.
  - Then: if `idx`==7, go to DONE; else `idx`++ and go to CHECK.
- DONE: `flush_done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- Outside the states named above, all load/write outputs are 0 and `arr_windex`=`arr_rindex`=`idx`.
- `idx` wraps only by returning to IDLE. It never increments past 7.

## Timing
- Reset values: state IDLE, `idx`=0, `tag_q`/`line_q`=0. All outputs are 0: `busy`, `flush_done`, `pmem_write`, `dirty_load`, `valid_load`, `pmem_address`, `pmem_wdata`, `arr_*`.
- Array reads are combinational. The CHECK decision uses same-cycle `valid_in`/`dirty_in`.
- The arrays' write-to-read bypass is never exercised: CLEAR and CHECK never occur in the same cycle.
- Latency, no dirty lines, INVALIDATE=0:
  - `flush_req` is sampled at edge 0.
  - CHECK occupies cycles 1–8.
  - `flush_done` is high in cycle 9.
  - `busy` falls in cycle 10.
- Latency per dirty line: +1 CLEAR cycle, plus WRITE cycles (N if `pmem_resp` is high in the Nth WRITE cycle, minimum 1).
- `pmem_write` stays high through the `pmem_resp` cycle and is low the next cycle.
- `flush_req` while busy, including the DONE cycle, is ignored. It is not queued.
- `pmem_resp` outside WRITE is ignored.
- `rst` mid-operation returns to IDLE on the next edge and abandons any write in flight. The memory side must tolerate `pmem_write` dropping before `pmem_resp`.

## Structure
- Shared cache package (`cache_pkg`) holds:
  - the state enum `flush_state_t`
  - S_OFFSET, S_INDEX(=3), S_TAG, S_LINE constants, shared with the arrays and the cache datapath
- The top-level module is a single FSM plus the `idx`, `tag_q` and `line_q` registers. No sub-module is needed.
- The external 2:1 mux on the array ports lives in the cache datapath, selected by `busy`.

## Test plan
- Empty cache, all valid=0 → `flush_done` in cycle 9 after the request; `pmem_write`, `dirty_load` and `valid_load` never assert.
- Set 3 valid+dirty, tag 0xABCDEF, line pattern P; `pmem_resp` delayed 4 cycles → `pmem_address`=0xABCDEF60 and `pmem_wdata`=P, both held 4 cycles; one `dirty_load` cycle with `arr_windex`=3; dirty[3]=0 after; `flush_done` in cycle 14.
- All 8 sets dirty, 1-cycle `pmem_resp` → 8 writes at indices 0..7 in order; `flush_done` in cycle 25; all dirty bits 0.
- INVALIDATE=1, set 5 valid and clean → no memory write; one CLEAR cycle with `valid_load`=1 and `arr_windex`=5; valid[5]=0.
- `rst` asserted during WRITE at set 2 → next cycle the engine is in IDLE and all outputs are 0; a late `pmem_resp` is ignored; a new `flush_req` restarts from set 0.
- `flush_req` held high across DONE → exactly one `flush_done` pulse; a new flush starts from the IDLE cycle after.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry constants used by the arrays, the cache
// datapath and the flush engine, plus the flush engine state encoding.
package cache_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
    localparam int S_LINE   = 256;
    localparam int NUM_SETS = 1 << S_INDEX;

    typedef enum logic [2:0] {
        FL_IDLE  = 3'd0,
        FL_CHECK = 3'd1,
        FL_WRITE = 3'd2,
        FL_CLEAR = 3'd3,
        FL_DONE  = 3'd4
    } flush_state_t;

endpackage

// File: rtl/cache_flush_engine.sv
// Walks every set of the cache, writes valid+dirty lines back to physical
// memory and clears their dirty (and optionally valid) bits.
module cache_flush_engine
    import cache_pkg::flush_state_t;
    import cache_pkg::S_INDEX;
    import cache_pkg::FL_IDLE;
    import cache_pkg::FL_CHECK;
    import cache_pkg::FL_WRITE;
    import cache_pkg::FL_CLEAR;
    import cache_pkg::FL_DONE;
#(
    parameter int S_OFFSET   = cache_pkg::S_OFFSET,
    parameter int S_TAG      = cache_pkg::S_TAG,
    parameter int S_LINE     = cache_pkg::S_LINE,
    parameter int INVALIDATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req,
    output logic                busy,
    output logic                flush_done,
    output logic [S_INDEX-1:0]  arr_rindex,
    input  logic                valid_in,
    input  logic                dirty_in,
    input  logic [S_TAG-1:0]    tag_in,
    input  logic [S_LINE-1:0]   line_in,
    output logic                dirty_load,
    output logic                valid_load,
    output logic [S_INDEX-1:0]  arr_windex,
    output logic                arr_datain,
    output logic [31:0]         pmem_address,
    output logic [S_LINE-1:0]   pmem_wdata,
    output logic                pmem_write,
    input  logic                pmem_resp
);

    localparam logic                INV      = (INVALIDATE != 0);
    localparam logic [S_INDEX-1:0]  LAST_IDX = '1;

    flush_state_t        state_reg, state_next;
    logic [S_INDEX-1:0]  idx_reg, idx_next;
    logic [S_TAG-1:0]    tag_q_reg;
    logic [S_LINE-1:0]   line_q_reg;
    logic                capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FL_IDLE;
            idx_reg    <= '0;
            tag_q_reg  <= '0;
            line_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (capture) begin
                tag_q_reg  <= tag_in;
                line_q_reg <= line_in;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        capture      = 1'b0;
        busy         = 1'b1;
        flush_done   = 1'b0;
        dirty_load   = 1'b0;
        valid_load   = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_reg)
            FL_IDLE: begin
                busy     = 1'b0;
                idx_next = '0;
                if (flush_req) begin
                    state_next = FL_CHECK;
                end
            end

            FL_CHECK: begin
                if (valid_in && dirty_in) begin
                    capture    = 1'b1;
                    state_next = FL_WRITE;
                end else if (INV && valid_in) begin
                    state_next = FL_CLEAR;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = FL_DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end

            // Address and data come only from the captured registers so they
            // hold steady for however long memory takes to respond.
            FL_WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q_reg, idx_reg, {S_OFFSET{1'b0}}};
                pmem_wdata   = line_q_reg;
                if (pmem_resp) begin
                    state_next = FL_CLEAR;
                end
            end

            FL_CLEAR: begin
                dirty_load = 1'b1;
                valid_load = INV;
                if (idx_reg == LAST_IDX) begin
                    state_next = FL_DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = FL_CHECK;
                end
            end

            // Index returns to 0 here so the index outputs read 0 in IDLE.
            FL_DONE: begin
                flush_done = 1'b1;
                idx_next   = '0;
                state_next = FL_IDLE;
            end

            default: begin
                busy       = 1'b0;
                idx_next   = '0;
                state_next = FL_IDLE;
            end
        endcase
    end

    assign arr_rindex = idx_reg;
    assign arr_windex = idx_reg;
    assign arr_datain = 1'b0;

endmodule

// File: tb/tb_cache_flush_engine.sv
// Scoreboard bench for cache_flush_engine: one instance with INVALIDATE=0 and
// one with INVALIDATE=1, behavioural arrays and a delayed-response memory.
`timescale 1ns/1ps
module tb_cache_flush_engine;
    import cache_pkg::*;

    localparam int NI = 2;

    typedef enum int {EV_WR, EV_CLR, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        int                inst;
        logic [31:0]       addr;
        logic [S_LINE-1:0] data;
        int                ncyc;
        logic [2:0]        windex;
        logic              vload;
        int                cyc;
    } ev_t;

    ev_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] flush_req = '0;
    logic [NI-1:0] busy, flush_done, dirty_load, valid_load, arr_datain;
    logic [NI-1:0] pmem_write, pmem_resp, valid_in, dirty_in;
    logic [NI-1:0][2:0]        arr_rindex, arr_windex;
    logic [NI-1:0][S_TAG-1:0]  tag_in;
    logic [NI-1:0][S_LINE-1:0] line_in, pmem_wdata;
    logic [NI-1:0][31:0]       pmem_address;

    logic [NI-1:0][7:0] vm, dm;
    logic [7:0] cfg_v = '0;
    logic [7:0] cfg_d = '0;
    logic load_cfg = 1'b0;
    logic [S_TAG-1:0]  tm [8];
    logic [S_LINE-1:0] lm [8];
    int wcnt [NI];
    int wr_n [NI];
    int resp_delay = 1;
    logic stray_resp = 1'b0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array and memory models
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (load_cfg) begin
                vm[i] <= cfg_v;
                dm[i] <= cfg_d;
            end else begin
                if (dirty_load[i]) dm[i][arr_windex[i]] <= arr_datain[i];
                if (valid_load[i]) vm[i][arr_windex[i]] <= arr_datain[i];
            end
            if (pmem_write[i] && !pmem_resp[i]) wcnt[i] <= wcnt[i] + 1;
            else wcnt[i] <= 0;
        end
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        assign valid_in[gi]  = vm[gi][arr_rindex[gi]];
        assign dirty_in[gi]  = dm[gi][arr_rindex[gi]];
        assign tag_in[gi]    = tm[arr_rindex[gi]];
        assign line_in[gi]   = lm[arr_rindex[gi]];
        assign pmem_resp[gi] = (pmem_write[gi] && (wcnt[gi] == resp_delay - 1)) || stray_resp;

        cache_flush_engine #(.INVALIDATE(gi)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush_req    (flush_req[gi]),
            .busy         (busy[gi]),
            .flush_done   (flush_done[gi]),
            .arr_rindex   (arr_rindex[gi]),
            .valid_in     (valid_in[gi]),
            .dirty_in     (dirty_in[gi]),
            .tag_in       (tag_in[gi]),
            .line_in      (line_in[gi]),
            .dirty_load   (dirty_load[gi]),
            .valid_load   (valid_load[gi]),
            .arr_windex   (arr_windex[gi]),
            .arr_datain   (arr_datain[gi]),
            .pmem_address (pmem_address[gi]),
            .pmem_wdata   (pmem_wdata[gi]),
            .pmem_write   (pmem_write[gi]),
            .pmem_resp    (pmem_resp[gi])
        );
    end

    task automatic chk(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string what, input int inst);
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_%s dut%0d: got event at cycle %0d, expected none pending", what, inst, cyc);
    endtask

    function automatic bit front_is(input int inst, input ev_kind_t k);
        return exp_q.size() > 0 && exp_q[0].inst == inst && exp_q[0].kind == k;
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents an event
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < NI; i++) wr_n[i] = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    if (pmem_write[i]) begin
                        if (!front_is(i, EV_WR)) unexpected("pmem_write", i);
                        else begin
                            e = exp_q[0];
                            chk("wr_addr", pmem_address[i], e.addr);
                            chk("wr_data", pmem_wdata[i], e.data);
                            wr_n[i]++;
                            if (pmem_resp[i]) begin
                                chk("wr_cycles", wr_n[i], e.ncyc);
                                $display("dut%0d write addr=%08h cycles=%0d", i, pmem_address[i], wr_n[i]);
                                void'(exp_q.pop_front());
                                wr_n[i] = 0;
                            end
                        end
                    end
                    if (dirty_load[i] || valid_load[i]) begin
                        if (!front_is(i, EV_CLR)) unexpected("load", i);
                        else begin
                            e = exp_q.pop_front();
                            chk("clr_dirty_load", dirty_load[i], 1'b1);
                            chk("clr_windex", arr_windex[i], e.windex);
                            chk("clr_valid_load", valid_load[i], e.vload);
                            $display("dut%0d clear windex=%0d valid_load=%0b", i, arr_windex[i], valid_load[i]);
                        end
                    end
                    if (flush_done[i]) begin
                        if (!front_is(i, EV_DONE)) unexpected("flush_done", i);
                        else begin
                            e = exp_q.pop_front();
                            chk("done_cycle", cyc, e.cyc);
                            $display("dut%0d flush_done at cycle %0d", i, cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_wr(input int inst, input logic [31:0] a, input logic [S_LINE-1:0] d, input int n);
        ev_t e;
        e = '{kind: EV_WR, inst: inst, addr: a, data: d, ncyc: n, windex: 3'd0, vload: 1'b0, cyc: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_clr(input int inst, input int w, input logic v);
        ev_t e;
        e = '{kind: EV_CLR, inst: inst, addr: 32'd0, data: '0, ncyc: 0, windex: 3'(w), vload: v, cyc: 0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int inst, input int c);
        ev_t e;
        e = '{kind: EV_DONE, inst: inst, addr: 32'd0, data: '0, ncyc: 0, windex: 3'd0, vload: 1'b0, cyc: c};
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] v, input logic [7:0] d);
        @(negedge clk);
        cfg_v = v;
        cfg_d = d;
        load_cfg = 1'b1;
        @(negedge clk);
        load_cfg = 1'b0;
    endtask

    task automatic pulse_req(input int inst);
        flush_req[inst] = 1'b1;
        @(negedge clk);
        flush_req[inst] = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    localparam logic [S_LINE-1:0] PAT = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                                         32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};

    initial begin
        int c0;
        logic [31:0] a3 [8];
        logic [31:0] w;
        a3 = '{32'h5A000000, 32'h5A000120, 32'h5A000240, 32'h5A000360,
               32'h5A000480, 32'h5A0005A0, 32'h5A0006C0, 32'h5A0007E0};
        for (int i = 0; i < 8; i++) begin
            tm[i] = '0;
            lm[i] = '0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_done", flush_done[i], 1'b0);
            chk("rst_pmem_write", pmem_write[i], 1'b0);
            chk("rst_addr", pmem_address[i], 32'd0);
            chk("rst_rindex", arr_rindex[i], 3'd0);
        end
        rst = 1'b0;

        // Empty cache
        load(8'h00, 8'h00);
        @(negedge clk); c0 = cyc;
        push_done(0, c0 + 9);
        pulse_req(0);
        drain("t1_drain");
        chk("t1_idle_busy", busy[0], 1'b0);

        // One dirty line at set 3, slow memory
        tm[3] = 24'hABCDEF;
        lm[3] = PAT;
        resp_delay = 4;
        load(8'b0000_1000, 8'b0000_1000);
        @(negedge clk); c0 = cyc;
        push_wr(0, 32'hABCDEF60, PAT, 4);
        push_clr(0, 3, 1'b0);
        push_done(0, c0 + 14);
        pulse_req(0);
        drain("t2_drain");
        chk("t2_dirty3", dm[0][3], 1'b0);
        chk("t2_valid3", vm[0][3], 1'b1);

        // All sets dirty, single-cycle memory
        for (int i = 0; i < 8; i++) begin
            tm[i] = 24'h5A0000 + 24'(i);
            w = 32'hD00D0000 + 32'(i);
            lm[i] = {8{w}};
        end
        resp_delay = 1;
        load(8'hFF, 8'hFF);
        @(negedge clk); c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            push_wr(0, a3[i], lm[i], 1);
            push_clr(0, i, 1'b0);
        end
        push_done(0, c0 + 25);
        pulse_req(0);
        drain("t3_drain");
        chk("t3_dirty_all", dm[0], 8'h00);
        chk("t3_valid_all", vm[0], 8'hFF);

        // Invalidating instance, clean valid line at set 5
        load(8'b0010_0000, 8'h00);
        @(negedge clk); c0 = cyc;
        push_clr(1, 5, 1'b1);
        push_done(1, c0 + 10);
        pulse_req(1);
        drain("t4_drain");
        chk("t4_valid_all", vm[1], 8'h00);

        // Reset during WRITE of set 2
        tm[2] = 24'h123456;
        lm[2] = ~PAT;
        resp_delay = 6;
        load(8'b0000_0100, 8'b0000_0100);
        push_wr(0, 32'h12345640, ~PAT, 6);
        pulse_req(0);
        begin
            int k;
            k = 0;
            while (!pmem_write[0] && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t5_write_seen", pmem_write[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy[0], 1'b0);
        chk("t5_done", flush_done[0], 1'b0);
        chk("t5_pmem_write", pmem_write[0], 1'b0);
        chk("t5_dirty_load", dirty_load[0], 1'b0);
        chk("t5_valid_load", valid_load[0], 1'b0);
        chk("t5_addr", pmem_address[0], 32'd0);
        chk("t5_wdata", pmem_wdata[0], '0);
        chk("t5_rindex", arr_rindex[0], 3'd0);
        chk("t5_windex", arr_windex[0], 3'd0);
        @(negedge clk);
        rst = 1'b0;
        stray_resp = 1'b1;
        @(negedge clk);
        stray_resp = 1'b0;
        chk("t5_stray_busy", busy[0], 1'b0);
        chk("t5_dirty_kept", dm[0][2], 1'b1);
        resp_delay = 1;
        @(negedge clk); c0 = cyc;
        push_wr(0, 32'h12345640, ~PAT, 1);
        push_clr(0, 2, 1'b0);
        push_done(0, c0 + 11);
        pulse_req(0);
        drain("t5_drain");
        chk("t5_dirty_cleared", dm[0][2], 1'b0);

        // flush_req held across DONE
        load(8'h00, 8'h00);
        @(negedge clk); c0 = cyc;
        push_done(0, c0 + 9);
        flush_req[0] = 1'b1;
        repeat (10) @(negedge clk);
        flush_req[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_idle_busy", busy[0], 1'b0);
        chk("t6_one_done", exp_q.size(), 0);
        @(negedge clk); c0 = cyc;
        push_done(0, c0 + 9);
        pulse_req(0);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
